// File: rtl/codificador_teclado_sinc.sv
// Clocked keypad encoder: 2-flop synchroniser, debounce FSM, highest-index priority
// encode, and a valid/ack event handshake with overrun and multi-key flags.
module codificador_teclado_sinc #(
    parameter int N_KEYS          = 4,
    parameter int CODE_W          = $clog2(N_KEYS),
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] in,
    output logic [CODE_W-1:0] out,
    output logic              press,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              overrun,
    output logic              multi
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CODE_W-1:0] out_q, out_d;
    logic              press_q, press_d;
    logic              key_valid_q, key_valid_d;
    logic              overrun_q, overrun_d;
    logic              multi_q, multi_d;

    logic              raw_any;
    logic [CODE_W-1:0] raw_code;
    logic              cnt_last;

    // Highest set index wins; only indices < N_KEYS can ever be produced.
    always_comb begin
        raw_any  = |sync2_q;
        raw_code = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (sync2_q[i]) raw_code = CODE_W'(i);
        end
        multi_d  = ($countones(sync2_q) > 1);
        cnt_last = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        out_d       = out_q;
        press_d     = press_q;
        overrun_d   = 1'b0;
        key_valid_d = key_valid_q && !key_ack;

        case (state_q)
            IDLE: begin
                if (raw_any) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                    cand_d  = raw_code;
                end
            end
            DEBOUNCE: begin
                if (!raw_any || (raw_code != cand_q)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    // Acceptance overrides any same-cycle ack: the new event stays pending.
                    state_d     = PRESSED;
                    cnt_d       = '0;
                    out_d       = cand_q;
                    press_d     = 1'b1;
                    key_valid_d = 1'b1;
                    overrun_d   = key_valid_q && !key_ack;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (!raw_any) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (raw_any) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    press_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            out_q       <= '0;
            press_q     <= 1'b0;
            key_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            multi_q     <= 1'b0;
        end else begin
            sync1_q     <= in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            out_q       <= out_d;
            press_q     <= press_d;
            key_valid_q <= key_valid_d;
            overrun_q   <= overrun_d;
            multi_q     <= multi_d;
        end
    end

    assign out       = out_q;
    assign press     = press_q;
    assign key_valid = key_valid_q;
    assign overrun   = overrun_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_codificador_teclado_sinc.sv
// Bench for codificador_teclado_sinc: run-length behavioural model checked every cycle,
// plus directed latency/handshake/reset checks with literal expectations.
module tb_codificador_teclado_sinc;

    localparam int N = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_k = 4'b0000;
    logic       key_ack = 1'b0;
    logic [1:0] out_k;
    logic       press, key_valid, overrun, multi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    codificador_teclado_sinc #(
        .N_KEYS(N),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in_k),
        .out(out_k),
        .press(press),
        .key_valid(key_valid),
        .key_ack(key_ack),
        .overrun(overrun),
        .multi(multi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a key is accepted after D+1 consecutive synchronised samples of
    // the same code, and released after D+1 consecutive all-zero samples.
    function automatic int top_code(input logic [3:0] v);
        for (int i = 3; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    logic [3:0] m_s1 = '0, m_s2 = '0;
    int         run_len = 0, zero_len = 0, prev_code = -1, cur_code = -1;
    bit         held = 0, m_kv = 0, m_ov = 0, m_multi = 0;
    logic [1:0] m_out = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; run_len = 0; zero_len = 0; prev_code = -1;
            held = 0; m_kv = 0; m_ov = 0; m_multi = 0; m_out = '0;
        end else begin
            cur_code = top_code(m_s2);
            m_ov     = 0;
            m_multi  = ($countones(m_s2) > 1);
            if (!held) begin
                if (cur_code < 0) run_len = 0;
                else if (run_len > 0 && cur_code != prev_code) run_len = 0;
                else run_len++;
                if (run_len == D + 1) begin
                    held    = 1;
                    run_len = 0;
                    m_ov    = m_kv && !key_ack;
                    m_out   = cur_code[1:0];
                    m_kv    = 1;
                end else if (m_kv && key_ack) begin
                    m_kv = 0;
                end
            end else begin
                if (cur_code < 0) zero_len++;
                else zero_len = 0;
                if (zero_len == D + 1) begin
                    held     = 0;
                    zero_len = 0;
                end
                if (m_kv && key_ack) m_kv = 0;
            end
            prev_code = cur_code;
            m_s2 = m_s1;
            m_s1 = in_k;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out", out_k, m_out);
            chk("model_press", press, held);
            chk("model_key_valid", key_valid, m_kv);
            chk("model_overrun", overrun, m_ov);
            chk("model_multi", multi, m_multi);
        end
    end

    // which: 0 = key_valid high, 1 = overrun high, 2 = press low
    task automatic wait_sig(input int which, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = key_valid;
                1:       hit = overrun;
                default: hit = !press;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL wait_%0d: timed out after %0d cycles", which, n);
        end
    endtask

    task automatic ack_once();
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_out", out_k, 0);
        chk("rst_press", press, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_multi", multi, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean press of key 2
        in_k = 4'b0100;
        wait_sig(0, n);
        chk("clean_latency", n - 1, 6);
        chk("clean_out", out_k, 2);
        chk("clean_press", press, 1);
        repeat (13) @(negedge clk);
        ack_once();
        chk("clean_ack_clears", key_valid, 0);
        in_k = 4'b0000;
        wait_sig(2, n);
        chk("clean_release_latency", n - 1, 6);

        // Bounce on key 1, then a dropout while held
        in_k = 4'b0010;
        repeat (3) @(negedge clk);
        in_k = 4'b0000;
        @(negedge clk);
        chk("bounce_no_early_event", key_valid, 0);
        in_k = 4'b0010;
        wait_sig(0, n);
        chk("bounce_latency", n - 1, 6);
        chk("bounce_out", out_k, 1);
        ack_once();
        in_k = 4'b0000;
        repeat (2) @(negedge clk);
        in_k = 4'b0010;
        repeat (10) @(negedge clk);
        chk("dropout_press_held", press, 1);
        chk("dropout_no_event", key_valid, 0);
        in_k = 4'b0000;
        wait_sig(2, n);

        // Priority and multi-key
        in_k = 4'b1011;
        wait_sig(0, n);
        chk("prio_out", out_k, 3);
        chk("prio_multi", multi, 1);
        ack_once();
        in_k = 4'b0011;
        repeat (8) @(negedge clk);
        chk("no_rollover_out", out_k, 3);
        chk("no_rollover_valid", key_valid, 0);
        chk("no_rollover_multi", multi, 1);
        in_k = 4'b0000;
        wait_sig(2, n);

        // Overrun: key 1 left unacked, then key 0
        in_k = 4'b0010;
        wait_sig(0, n);
        in_k = 4'b0000;
        wait_sig(2, n);
        in_k = 4'b0001;
        wait_sig(1, n);
        chk("overrun_latency", n - 1, 6);
        chk("overrun_out", out_k, 0);
        chk("overrun_valid", key_valid, 1);
        @(negedge clk);
        chk("overrun_one_cycle", overrun, 0);
        in_k = 4'b0000;
        wait_sig(2, n);

        // Ack on the acceptance edge while still valid: no overrun
        in_k = 4'b0100;
        repeat (6) @(negedge clk);
        key_ack = 1'b1;
        @(negedge clk);
        key_ack = 1'b0;
        chk("ack_accept_no_overrun", overrun, 0);
        chk("ack_accept_valid", key_valid, 1);
        chk("ack_accept_out", out_k, 2);
        in_k = 4'b0000;
        wait_sig(2, n);

        // Asynchronous reset mid-debounce (counter at 2), outputs non-zero beforehand
        in_k = 4'b1000;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", out_k, 0);
        chk("async_rst_valid", key_valid, 0);
        chk("async_rst_press", press, 0);
        chk("async_rst_overrun", overrun, 0);
        chk("async_rst_multi", multi, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_sig(0, n);
        chk("post_rst_latency", n - 1, 6);
        chk("post_rst_out", out_k, 3);
        ack_once();
        in_k = 4'b0000;
        wait_sig(2, n);

        // Ack with no pending event
        key_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ack_valid", key_valid, 0);
            chk("idle_ack_overrun", overrun, 0);
            chk("idle_ack_press", press, 0);
        end
        key_ack = 1'b0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
